// File: rtl/accu_pkg.sv
// Shared types and the round-and-saturate mean helper for the 8-sample accumulator path.
package accu_pkg;

  localparam int ACCU_SUM_W = 10;
  localparam int ACCU_SHIFT = 3;
  localparam int ACCU_AVG_W = ACCU_SUM_W - ACCU_SHIFT;

  typedef logic [ACCU_SUM_W-1:0] sum_t;
  typedef logic [ACCU_AVG_W-1:0] avg_t;

  localparam logic [ACCU_SUM_W:0] ACCU_RND     = (ACCU_SUM_W+1)'(1 << (ACCU_SHIFT - 1));
  localparam logic [ACCU_SUM_W:0] ACCU_AVG_MAX = (ACCU_SUM_W+1)'((1 << ACCU_AVG_W) - 1);

  // One extra bit keeps the rounding carry; the top sums round up past the
  // avg range, so they clamp to all-ones instead of wrapping to zero.
  function automatic avg_t avg_round_sat(input sum_t sum);
    logic [ACCU_SUM_W:0] rnd;
    rnd = ({1'b0, sum} + ACCU_RND) >> ACCU_SHIFT;
    if (rnd > ACCU_AVG_MAX) return '1;
    return rnd[ACCU_AVG_W-1:0];
  endfunction

endpackage

// File: rtl/accu_fifo_core.sv
// Parameterised first-word-fall-through FIFO; level counter separates full from empty.
module accu_fifo_core #(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic [W-1:0]  wdata,
  input  logic          pop_req,
  output logic          push_ok,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push_req && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and level define what is valid,
  // and resetting the array would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/accu_result_buf.sv
// Result buffer behind the accumulator: FWFT FIFO, rounded mean and drop statistics.
module accu_result_buf
  import accu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SUM_W  = ACCU_SUM_W,
  parameter int SHIFT  = ACCU_SHIFT,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [SUM_W-1:0]         in_sum,
  input  logic                     out_ready,
  input  logic                     clr_stat,
  output logic                     out_valid,
  output logic [SUM_W-1:0]         out_sum,
  output logic [SUM_W-SHIFT-1:0]   out_avg,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  logic             push_ok;
  logic             empty;
  logic [SUM_W-1:0] head;
  logic             drop;

  accu_fifo_core #(
    .DEPTH (DEPTH),
    .W     (SUM_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (in_valid),
    .wdata    (in_sum),
    .pop_req  (out_ready),
    .push_ok  (push_ok),
    .rdata    (head),
    .level    (level),
    .empty    (empty)
  );

  assign out_valid = !empty;
  // Gating keeps the never-written storage from showing through when empty.
  assign out_sum   = out_valid ? head : '0;
  assign out_avg   = avg_round_sat(out_sum);
  assign drop      = in_valid && !push_ok;

  // A drop in the same cycle as clr_stat restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_stat)            drop_cnt <= DROP_W'(1);
      else if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end else if (clr_stat) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: doc/accu_result_buf.md
Name: accu_result_buf

Overview:
- Sits directly downstream of the 8-sample accumulator and consumes its 10-bit sum on each single-cycle result pulse.
- That producer has no backpressure, so this block captures every result into a small FIFO.
- It presents each entry as the raw sum plus a rounded mean, using a valid/ready handshake towards the consumer.
- Overflow is counted, never silently lost.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
SUM_W, 10, width of incoming sum
SHIFT, 3, log2 of samples per sum (8 samples)
DROP_W, 8, width of drop counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  single-cycle result pulse from accumulator
in_sum  in  SUM_W  accumulated sum, qualified by in_valid
out_ready  in  1  consumer accepts head entry
clr_stat  in  1  synchronous clear of overflow and drop_cnt
out_valid  out  1  head entry available
out_sum  out  SUM_W  head entry raw sum
out_avg  out  SUM_W-SHIFT  head entry rounded mean
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one result dropped
drop_cnt  out  DROP_W  saturating count of dropped results

Behaviour:
- Reset:
  - rst asserted clears pointers and sets level=0 immediately; the clear is asynchronous, mid-operation included, and all stored entries are lost.
  - Reset also forces out_valid=0, overflow=0, drop_cnt=0.
  - out_sum and out_avg read 0 while empty.
- Handshake:
  - Pop occurs when out_valid && out_ready in the same cycle.
  - out_sum and out_avg hold stable while out_valid=1 and out_ready=0.
- Write and latency:
  - A push is accepted when in_valid=1 and (level<DEPTH, or a pop occurs in the same cycle).
  - Latency from push to output is 1 cycle: a push at edge N into an empty FIFO gives out_valid=1 after edge N.
  - Storage is first-word fall-through; the head entry is driven from the storage read at rd_ptr.
- Simultaneous push and pop:
  - Level is unchanged and both pointers advance.
  - This holds when full, so a full FIFO with a pop in progress still accepts the push.
  - When empty, a simultaneous pop is impossible because out_valid=0, so the push alone is taken.
- Drop:
  - Occurs when in_valid=1, level==DEPTH and there is no pop.
  - The entry is discarded and FIFO contents are unchanged.
  - overflow is set to 1 on the next edge.
  - drop_cnt increments, saturating at 2^DROP_W-1 with no wrap.
- clr_stat:
  - Zeroes overflow and drop_cnt on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
  - FIFO contents are unaffected.
- Pointers: log2(DEPTH) bits each, wrapping modulo DEPTH. level is tracked in a separate counter, which distinguishes full from empty.
- Mean arithmetic:
  - out_avg = (out_sum + 2^(SHIFT-1)) >> SHIFT, computed in SUM_W+1 bits, then truncated to SUM_W-SHIFT bits.
  - With the defaults, the maximum sum is 1020, giving (1020+4)>>3 = 128, which fits in 7 bits (max representable 127).
  - Saturation therefore applies: results above 2^(SUM_W-SHIFT)-1 clamp to all-ones, so sum 1020 gives avg 127.
  - The mean is combinational from the head entry, with no extra latency.
- in_sum is sampled only when in_valid=1; its value is ignored otherwise.
- No X may propagate on outputs after reset.

Decomposition:
- Package accu_pkg holds:
  - ACCU_SUM_W=10, ACCU_SHIFT=3, ACCU_AVG_W=7
  - a sum_t typedef for the 10-bit sum
  - a helper function avg_round_sat(sum) implementing the round and saturate rule
- One sub-module, accu_fifo_core: a parameterised FWFT FIFO (storage, pointers, level, push/pop), reused elsewhere.
- The top level adds the drop/overflow statistics and the mean computation.

Test Plan:
- Push three pulses, in_sum=100, 200, 300, with out_ready=0 → level=3, out_sum=100, out_avg=13 (104>>3), held stable. Then raise out_ready for 3 cycles → out_sum 100, 200, 300 in order, then out_valid=0, level=0.
- Push 5 results (10, 20, 30, 40, 50) with out_ready=0, DEPTH=4 → the 50 is dropped, overflow=1, drop_cnt=1, level=4. Draining yields 10, 20, 30, 40 only.
- Fill to level=4, then in one cycle pulse in_valid with in_sum=77 and out_ready=1 → head pops, 77 accepted, level stays 4, drop_cnt unchanged.
- Mean rounding: in_sum=1020 → out_avg=127 (saturated); in_sum=11 → 1; in_sum=12 → 2; in_sum=0 → 0.
- Force 260 drops with DROP_W=8 → drop_cnt stops at 255. Then clr_stat with a concurrent drop → overflow=1, drop_cnt=1 next cycle.
- Assert rst mid-cycle with level=3 and out_valid=1 → out_valid=0, level=0 and overflow=0 immediately, without waiting for a clock edge. After release, a single push of 8 appears with out_avg=1.
